// File: rtl/alu_op_sequencer.sv
// Command sequencer for an external combinational ALU. Commands are queued in a FIFO
// and issued one at a time. Each result is held until the consumer accepts it.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    output logic [2:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_err,
    output logic [CNT_W-1:0] done_cnt,
    output logic [7:0]       err_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    function automatic logic is_supported(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd7);
    endfunction

    cmd_t             mem_q [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    state_e           state_q, state_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic             res_valid_q, res_valid_d, res_err_q, res_err_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             push, pop, dispatch;

    // Readiness depends only on registered occupancy, so a same-cycle pop never frees a slot early.
    assign cmd_ready = rst_n && (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_err_d   = res_err_q;
        res_data_d  = res_data_q;
        done_cnt_d  = done_cnt_q;
        err_cnt_d   = err_cnt_q;
        dispatch    = 1'b0;

        case (state_q)
            IDLE: dispatch = (count_q != '0);
            EXEC: begin
                res_data_d  = alu_result;
                res_err_d   = 1'b0;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (res_valid_q && res_ready) begin
                    done_cnt_d = done_cnt_q + 1'b1;
                    if (res_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
                    if (count_q != '0) begin
                        dispatch = 1'b1;
                    end else begin
                        res_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Unsupported opcodes skip the ALU and leave its operands untouched.
        if (dispatch) begin
            if (is_supported(head.op)) begin
                alu_op_d    = head.op;
                alu_a_d     = head.a;
                alu_b_d     = head.b;
                res_valid_d = 1'b0;
                state_d     = EXEC;
            end else begin
                res_data_d  = '0;
                res_err_d   = 1'b1;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
        end
        pop = dispatch;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage carries no reset; occupancy and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
            done_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
            res_data_q  <= res_data_d;
            done_cnt_q  <= done_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;
    assign res_data  = res_data_q;
    assign done_cnt  = done_cnt_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench: a result scoreboard built from the operation rules,
// plus directed latency, backpressure, reset and counter-limit scenarios.
module tb_alu_op_sequencer;
    logic        clk, rst_n;
    logic        cmd_valid, res_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;

    logic        cmd_ready, res_valid, res_err;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result, res_data;
    logic [15:0] done_cnt;
    logic [7:0]  err_cnt;

    logic        cmd_ready_w4, res_valid_w4, res_err_w4;
    logic [2:0]  alu_op_w4;
    logic [31:0] alu_a_w4, alu_b_w4, alu_result_w4, res_data_w4;
    logic [3:0]  done_cnt_w4;
    logic [7:0]  err_cnt_w4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_m   = 0;
    int err_m    = 0;
    logic [32:0] exp_q[$];
    int          hs_cyc[$];
    logic        prev_valid, prev_hs, prev_err, rand_ready;
    logic [31:0] prev_data;

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a * b;
            3'd7:    return a ^ b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Expected {err, data} for one command.
    function automatic logic [32:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 3'd0 || op == 3'd1 || op == 3'd7) return {1'b0, alu_fn(op, a, b)};
        return {1'b1, 32'h0};
    endfunction

    assign alu_result    = alu_fn(alu_op, alu_a, alu_b);
    assign alu_result_w4 = alu_fn(alu_op_w4, alu_a_w4, alu_b_w4);

    alu_op_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    alu_op_sequencer #(.DEPTH(4), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w4),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op(alu_op_w4), .alu_a(alu_a_w4), .alu_b(alu_b_w4), .alu_result(alu_result_w4),
        .res_valid(res_valid_w4), .res_ready(res_ready), .res_data(res_data_w4), .res_err(res_err_w4),
        .done_cnt(done_cnt_w4), .err_cnt(err_cnt_w4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scores the handshakes about to happen at the next edge, then advances one cycle.
    task automatic step();
        logic        push, hs;
        logic [32:0] e;
        if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
        push = cmd_valid && cmd_ready;
        hs   = res_valid && res_ready;
        if (prev_valid && !prev_hs) begin
            check("hold_valid", res_valid, 1'b1);
            check("hold_data", res_data, prev_data);
            check("hold_err", res_err, prev_err);
        end
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("res_data", res_data, e[31:0]);
                check("res_err", res_err, e[32]);
                check("w4_res", {res_valid_w4, res_err_w4, res_data_w4}, {1'b1, e});
                done_m++;
                if (e[32] && err_m < 255) err_m++;
                hs_cyc.push_back(cyc);
            end
        end
        if (push) exp_q.push_back(ref_result(cmd_op, cmd_a, cmd_b));
        prev_valid = res_valid;
        prev_hs    = hs;
        prev_data  = res_data;
        prev_err   = res_err;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic acc;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        for (int i = 0; i < 100; i++) begin
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) begin
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        int n;
        res_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || res_valid) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("drain_timeout", 1'b0, 1'b1);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_done"}, done_cnt, done_m % 65536);
        check({tag, "_err"}, err_cnt, err_m);
        check({tag, "_done_w4"}, done_cnt_w4, done_m % 16);
        check({tag, "_err_w4"}, err_cnt_w4, err_m);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, {cmd_ready, cmd_ready_w4}, 2'b00);
        check({tag, "_res"}, {res_valid, res_err, res_data}, 34'h0);
        check({tag, "_alu"}, {alu_op, alu_a, alu_b}, 67'h0);
        check({tag, "_cnt"}, {done_cnt, err_cnt, done_cnt_w4, err_cnt_w4}, 32'h0);
    endtask

    function automatic logic [2:0] rand_op();
        int r = $urandom_range(0, 9);
        if (r < 3) return 3'd0;
        if (r < 6) return 3'd1;
        if (r < 8) return 3'd7;
        return 3'($urandom_range(2, 6));
    endfunction

    task automatic throughput(input logic supported, input int gap);
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(supported ? 3'd0 : 3'd4, $urandom, $urandom);
        check("bp_cmd_ready", {cmd_ready, cmd_ready_w4}, 2'b00);
        check("bp_res_valid", res_valid, 1'b1);
        check("bp_head_data", res_data, exp_q[0][31:0]);
        for (int i = 0; i < 3; i++) step();
        hs_cyc.delete();
        drain();
        check("bp_result_count", hs_cyc.size(), 5);
        for (int i = 1; i < hs_cyc.size(); i++)
            check(supported ? "tput_supported" : "tput_unsupported", hs_cyc[i] - hs_cyc[i-1], gap);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        cmd_op = '0;
        cmd_a = '0;
        cmd_b = '0;
        rand_ready = 1'b0;
        prev_valid = 1'b0;
        prev_hs = 1'b0;
        prev_err = 1'b0;
        prev_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        #1;
        check("ready_after_release", cmd_ready, 1'b1);

        // Add with latency: result valid two edges after acceptance.
        res_ready = 1'b1;
        send(3'd0, 32'd1, 32'd2);
        check("lat_edge_n", res_valid, 1'b0);
        step();
        check("lat_edge_n1", res_valid, 1'b0);
        step();
        check("lat_edge_n2", {res_valid, res_err, res_data}, {1'b1, 1'b0, 32'd3});
        drain();
        check_counters("add");

        // Unsupported latency: result valid one edge after acceptance.
        send(3'd5, 32'd9, 32'd9);
        step();
        check("lat_unsup", {res_valid, res_err, res_data}, {1'b1, 1'b1, 32'd0});
        drain();

        // Mixed stream, including an add that wraps.
        send(3'd1, 32'd6, 32'd7);
        send(3'd7, 32'hFF, 32'h0F);
        send(3'd3, 32'd5, 32'd5);
        send(3'd0, 32'hFFFF_FFFF, 32'd1);
        drain();
        check_counters("mixed");

        throughput(1'b1, 2);
        throughput(1'b0, 1);
        check_counters("backpressure");

        // Random traffic with random consumer stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_op(), $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_ready = 1'b0;
        drain();
        check_counters("random");

        // Reset while in EXEC with three commands queued.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(3'd1, $urandom, $urandom);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("pre_reset_in_exec", res_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        exp_q.delete();
        done_m = 0;
        err_m = 0;
        prev_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_stale_result", res_valid, 1'b0);
        end
        send(3'd0, 32'd10, 32'd20);
        drain();
        check_counters("post_reset");

        // Counter limits: narrow done counter wraps, error counter saturates.
        for (int i = 0; i < 16; i++) send(3'($urandom_range(2, 6)), $urandom, $urandom);
        drain();
        check("done_w4_wrap", done_cnt_w4, 4'd1);
        check_counters("wrap");
        for (int i = 0; i < 250; i++) send(3'($urandom_range(2, 6)), $urandom, $urandom);
        drain();
        check("err_saturated", err_cnt, 8'd255);
        check_counters("saturate");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
Parameters:
REQ-001 SHALL provide parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL provide parameter CNT_W, default 16, width of completed-operation counter.
Ports:
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have cmd_valid  input  1  command offered.
REQ-006 SHALL have cmd_ready  output  1  FIFO can accept a command.
REQ-007 SHALL have cmd_op  input  3  operation code (0 add, 1 mul, 7 exor).
REQ-008 SHALL have cmd_a, cmd_b  input  32 each  operands.
REQ-009 SHALL have alu_op  output  3  registered operation driven to the downstream alu.
REQ-010 SHALL have alu_a, alu_b  output  32 each  registered operands driven to the alu.
REQ-011 SHALL have alu_result  input  32  combinational alu result.
REQ-012 SHALL have res_valid  output  1  result available.
REQ-013 SHALL have res_ready  input  1  consumer accepts result.
REQ-014 SHALL have res_data  output  32  result value.
REQ-015 SHALL have res_err  output  1  result belongs to an unsupported opcode.
REQ-016 SHALL have done_cnt  output  CNT_W  completed results, wraps modulo 2^CNT_W.
REQ-017 SHALL have err_cnt  output  8  unsupported-opcode results, saturates at 255.

Function
REQ-018 SHALL store {op,a,b} in a DEPTH-entry FIFO on any rising edge where cmd_valid && cmd_ready.
REQ-019 SHALL drive cmd_ready = 1 exactly when FIFO occupancy < DEPTH, from registered occupancy only; a pop in the same cycle does not raise cmd_ready.
REQ-020 SHALL implement states IDLE, EXEC, RESP.
REQ-021 IDLE with FIFO non-empty: pop head; supported op -> load alu_op/alu_a/alu_b, go EXEC; unsupported op (2..6) -> res_data=0, res_err=1, res_valid=1, go RESP, alu outputs unchanged.
REQ-022 EXEC: capture alu_result into res_data, res_err=0, res_valid=1, go RESP (exactly one cycle in EXEC).
REQ-023 RESP: hold res_valid, res_data, res_err stable until res_valid && res_ready.
REQ-024 On RESP handshake: increment done_cnt; if res_err also increment err_cnt (no change at 255); if FIFO non-empty pop and apply REQ-021 transition in same edge, else res_valid=0, go IDLE.
REQ-025 Latency: command accepted at edge N, FIFO and IDLE empty -> supported-op result valid after edge N+2, unsupported after N+1.
REQ-026 Sustained throughput with res_ready=1: one supported result per 2 cycles, one unsupported result per cycle.
REQ-027 SHALL preserve command order across supported and unsupported ops.
REQ-028 Simultaneous push and pop: both occur; occupancy unchanged; push into empty FIFO is not popped on the same edge.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-030 res_ready while res_valid=0 SHALL have no effect.
REQ-031 Arithmetic is owned by the alu; this block SHALL NOT modify alu_result bits.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, FIFO empty, cmd_ready=1 only after release (0 while asserted), res_valid=0, res_err=0, res_data=0, alu_op=0, alu_a=0, alu_b=0, done_cnt=0, err_cnt=0.
REQ-033 Reset asserted mid-operation SHALL discard all queued and in-flight commands; no result produced after release.
REQ-034 First command SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Add: cmd {0,1,2}, res_ready=1, alu model attached -> res_data=3, res_err=0 two edges after accept, done_cnt=1.
REQ-036 Mixed stream: {1,6,7}, {7,0xFF,0x0F}, {3,5,5}, {0,0xFFFFFFFF,1} -> in order 42, 0xF0, 0 err=1, 0 (wrap); done_cnt=4, err_cnt=1.
REQ-037 Backpressure: res_ready=0, push 5 commands with DEPTH=4 -> 4 queued plus 1 popped in flight, cmd_ready=0, res_data stable; release res_ready -> all 5 results in order.
REQ-038 Reset mid-EXEC with 3 queued -> res_valid=0, counters 0, no output after release; new {0,10,20} -> 30.
REQ-039 Saturation/wrap: 256 unsupported commands -> err_cnt=255; CNT_W=4 with 17 commands -> done_cnt=1.
